imem_boot_loader: RTL and testbench

Boot-time controller that fills the 64-word instruction memory from an 8-bit byte stream, then releases the core. Sits between an external byte source (UART receiver or testbench) and the instruction memory's write port. Holds the single-cycle core in reset while loading. Runs a length-prefixed protocol with a valid/ready handshake and reports completion or error.

---
 rtl/imem_loader_pkg.sv | 41 ++++
 rtl/byte_packer.sv | 36 +++
 rtl/imem_boot_loader.sv | 119 +++++++++++
 tb/tb_imem_boot_loader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int WORDS_DEF = 64;
  localparam int AW_DEF    = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_RECV  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  typedef struct packed {
    logic rx_ready;
    logic busy;
    logic cpu_hold;
    logic done;
    logic err;
    logic mem_we;
  } outs_t;

  // Moore output decode; the top registers it from the next state.
  function automatic outs_t state_outs(input state_e s);
    outs_t o;
    o = '{rx_ready: 1'b0, busy: 1'b0, cpu_hold: 1'b1, done: 1'b0, err: 1'b0, mem_we: 1'b0};
    case (s)
      S_IDLE:  o.cpu_hold = 1'b1;
      S_LEN:   begin o.rx_ready = 1'b1; o.busy = 1'b1; end
      S_RECV:  begin o.rx_ready = 1'b1; o.busy = 1'b1; end
      S_WRITE: begin o.busy = 1'b1; o.mem_we = 1'b1; end
      S_DONE:  begin o.cpu_hold = 1'b0; o.done = 1'b1; end
      S_ERR:   o.err = 1'b1;
      default: o.cpu_hold = 1'b1;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles four stream bytes into a little-endian 32-bit word.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  byte_i,
  output logic [31:0] word,
  output logic        full
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  // Lane counter and assembly register; lane 0 is the first byte of a word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (clr) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (push) begin
      word_q[{cnt_q, 3'b000} +: 8] <= byte_i;
      cnt_q                        <= cnt_q + 2'd1;
    end else begin
      cnt_q  <= cnt_q;
      word_q <= word_q;
    end
  end

  assign word = word_q;
  // High while the next push completes the word.
  assign full = (cnt_q == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: length-prefixed byte stream into instruction memory, holding the core meanwhile.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int WORDS = WORDS_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e        state_q, state_d;
  outs_t         outs_q;
  logic [7:0]    n_q, n_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          accept;
  logic          pk_clr;
  logic          pk_push;
  logic          pk_full;
  logic [31:0]   pk_word;

  assign accept  = rx_valid && outs_q.rx_ready;
  assign pk_push = accept && (state_q == S_RECV);

  byte_packer u_packer (
    .clk    (clk),
    .rst    (rst),
    .clr    (pk_clr),
    .push   (pk_push),
    .byte_i (rx_data),
    .word   (pk_word),
    .full   (pk_full)
  );

  // Next-state, length latch and word-index logic.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    pk_clr  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          idx_d   = '0;
          pk_clr  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN: begin
        if (accept) begin
          if ((rx_data == 8'd0) || ({1'b0, rx_data} > 9'(WORDS))) begin
            state_d = S_ERR;
          end else begin
            n_d     = rx_data;
            state_d = S_RECV;
          end
        end else begin
          state_d = S_LEN;
        end
      end
      S_RECV: begin
        if (accept && pk_full) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_RECV;
        end
      end
      S_WRITE: begin
        idx_d = idx_q + AW'(1);
        // Index width may be narrower than N; compare in N's width.
        if (8'(idx_q) == (n_q - 8'd1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      outs_q  <= state_outs(S_IDLE);
      n_q     <= 8'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      outs_q  <= state_outs(state_d);
      n_q     <= n_d;
      idx_q   <= idx_d;
    end
  end

  assign rx_ready = outs_q.rx_ready;
  assign busy     = outs_q.busy;
  assign cpu_hold = outs_q.cpu_hold;
  assign done     = outs_q.done;
  assign err      = outs_q.err;
  assign mem_we   = outs_q.mem_we;
  assign mem_addr = {{(30-AW){1'b0}}, idx_q, 2'b00};
  // The packer register is static between the 4th byte and the write cycle.
  assign mem_wd   = pk_word;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader with a queue-based reference of the expected writes.
module tb_imem_boot_loader;

  localparam int WORDS = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        rst, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, mem_we, cpu_hold, busy, done, err;
  logic [31:0] mem_addr, mem_wd;

  int n_checks = 0;
  int n_pass   = 0;
  int vmode    = 2;
  bit tog      = 1'b0;

  logic [7:0]  tx_q[$];
  logic [7:0]  payload[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  imem_boot_loader #(.WORDS(WORDS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Byte source: the DUT takes a byte on an edge with valid && ready.
  always @(posedge clk) begin
    if (!rst && rx_valid && rx_ready && tx_q.size() > 0) void'(tx_q.pop_front());
  end

  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    forever begin
      bit go;
      @(negedge clk);
      tog = ~tog;
      case (vmode)
        0:       go = ($urandom_range(0, 3) != 0);
        1:       go = tog;
        default: go = 1'b1;
      endcase
      if (go && tx_q.size() > 0) begin
        rx_valid = 1'b1;
        rx_data  = tx_q[0];
      end else begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end
    end
  end

  // Write monitor against the expected-write queue.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        check("wr_addr", mem_addr, exp_addr_q.pop_front());
        check("wr_data", mem_wd, exp_data_q.pop_front());
      end
    end
  end

  // One session: count byte n, then the payload bytes; optionally a stray start mid-RECV.
  task automatic run_session(input int n, input int mode, input bit inject, input int exp_lat);
    bit ok;
    int cyc;
    ok = (n >= 1) && (n <= WORDS);
    vmode = mode;
    if (ok) begin
      for (int w = 0; w < n; w++) begin
        exp_addr_q.push_back(32'(w * 4));
        exp_data_q.push_back({payload[4*w+3], payload[4*w+2], payload[4*w+1], payload[4*w]});
      end
    end
    tx_q.push_back(8'(n));
    foreach (payload[i]) tx_q.push_back(payload[i]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_hold", {30'd0, done, cpu_hold}, 32'd1);
    cyc = 0;
    while (!(done || err) && cyc < 3000) begin
      start = (inject && cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 3000) check("timeout", 32'd0, 32'd1);
    if (exp_lat > 0) check("latency", 32'(cyc), 32'(exp_lat));
    check("end_flags", {28'd0, busy, cpu_hold, done, err}, ok ? 32'b0010 : 32'b0101);
    check("end_addr", mem_addr, ok ? 32'((n % WORDS) * 4) : 32'd0);
    check("writes_left", 32'(exp_addr_q.size()), 32'd0);
    check("bytes_left", 32'(tx_q.size()), 32'd0);
    payload.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_payload(input int n);
    payload.delete();
    for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_flags", {26'd0, rx_ready, mem_we, busy, done, err, cpu_hold}, 32'd1);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wd", mem_wd, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    payload = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    run_session(2, 2, 1'b0, 11);

    rand_payload(1);
    run_session(1, 1, 1'b0, 0);

    run_session(0, 2, 1'b0, 1);
    run_session(65, 2, 1'b0, 1);

    rand_payload(64);
    run_session(64, 2, 1'b0, 321);

    rand_payload(3);
    run_session(3, 0, 1'b1, 0);
    rand_payload(1);
    run_session(1, 0, 1'b0, 0);

    // Reset in the middle of receiving the first word.
    vmode = 2;
    tx_q.push_back(8'd2);
    for (int i = 0; i < 8; i++) tx_q.push_back(8'($urandom));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tx_q.delete();
    @(negedge clk);
    check("rst1_flags", {26'd0, rx_ready, mem_we, busy, done, err, cpu_hold}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst2_flags", {26'd0, rx_ready, mem_we, busy, done, err, cpu_hold}, 32'd1);
    check("rst2_wd", mem_wd, 32'd0);

    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 8);
      rand_payload(n);
      run_session(n, $urandom_range(0, 2), 1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
